// File: rtl/wptr_full_ctrl_if.sv
// Write-side bundle between the FIFO write controller and its producer / read-domain synchronizer.
// master drives the request side; slave is the controller that owns pointers and flags.
interface wptr_full_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              winc;
  logic [ADDR_W:0]   wq2_rptr;
  logic              wovf_clr;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr;
  logic              wfull;
  logic              walmost_full;
  logic [ADDR_W:0]   wlevel;
  logic              woverflow;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer / full-flag controller for an asynchronous FIFO.
// Keeps binary and Gray write pointers, and derives full, almost-full, level and sticky overflow.
module wptr_full_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int AFULL_TH = 28
) (
  input logic           clk,
  input logic           rst_n,
  wptr_full_ctrl_if.slave bus
);

  localparam int              PW        = ADDR_W + 1;
  localparam logic [ADDR_W:0] AFULL_LVL = PW'(AFULL_TH);

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wgray;
  logic [ADDR_W:0] wlevel_q;
  logic            wfull_q;
  logic            walmost_q;
  logic            wovf_q;

  logic            accept;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] rptr_full_cmp;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] wlevel_next;
  logic            wfull_next;
  logic            walmost_next;
  logic            wovf_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  // Full means the next write pointer equals the read pointer with its top two Gray bits inverted.
  always_comb begin
    accept        = bus.winc & ~wfull_q;
    wbin_next     = wbin + {{ADDR_W{1'b0}}, accept};
    wgray_next    = (wbin_next >> 1) ^ wbin_next;
    rptr_full_cmp = {~bus.wq2_rptr[ADDR_W:ADDR_W-1], bus.wq2_rptr[ADDR_W-2:0]};
    wfull_next    = (wgray_next == rptr_full_cmp);
    wlevel_next   = wbin_next - rbin;
    walmost_next  = (wlevel_next >= AFULL_LVL);
    wovf_next     = wovf_q;
    if (bus.winc && wfull_q) begin
      wovf_next = 1'b1;
    end else if (bus.wovf_clr) begin
      wovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin      <= '0;
      wgray     <= '0;
      wlevel_q  <= '0;
      wfull_q   <= 1'b0;
      walmost_q <= 1'b0;
      wovf_q    <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wgray     <= wgray_next;
      wlevel_q  <= wlevel_next;
      wfull_q   <= wfull_next;
      walmost_q <= walmost_next;
      wovf_q    <= wovf_next;
    end
  end

  // wptr crosses into the read domain, so it comes straight from the Gray flop.
  assign bus.waddr        = wbin[ADDR_W-1:0];
  assign bus.wptr         = wgray;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;

endmodule
